// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 mux: one-hot grant, registered 2-bit select,
// grants bounded by a hold timeout and separated by at least one dead cycle.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [1:0] o_sel,
    output logic [3:0] o_gnt,
    output logic       o_busy
);

    localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_last;
    logic [1:0]      r_sel;
    logic [3:0]      r_gnt;
    logic            r_busy;
    logic [CW-1:0]   r_cnt;

    logic [1:0]      w_winner;
    logic [1:0]      w_cand;
    logic            w_any;
    logic            w_release;

    // Rotating priority search: last+1 first, last itself lowest; later iterations
    // (lower offsets) override earlier ones so the nearest requester wins.
    always_comb begin
        w_winner = r_last;
        w_cand   = 2'b00;
        w_any    = |i_req;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_last + 2'(k + 1);
            if (i_req[w_cand]) begin
                w_winner = w_cand;
            end else begin
                w_winner = w_winner;
            end
        end
    end

    // Release conditions for the current owner; any combination yields one release.
    always_comb begin
        w_release = i_done | ~i_req[r_sel] | (r_cnt == CW'(MAX_HOLD - 1));
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_sel   <= w_winner;
                        r_last  <= w_winner;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    // sel is deliberately left untouched so the mux output holds through the dead cycle
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_sel  = r_sel;
    assign o_gnt  = r_gnt;
    assign o_busy = r_busy;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a grant-length based reference model.
module tb_mux_sel_arbiter;

    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] o_sel;
    logic [3:0] o_gnt;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    // reference model: owner index (-1 none), last owner, shown select, cycles granted so far
    int m_owner;
    int m_last;
    int m_sel;
    int m_held;

    mux_sel_arbiter #(.MAX_HOLD(MH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (req),
        .i_done  (done),
        .o_sel   (o_sel),
        .o_gnt   (o_gnt),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) until some grant is visible; n = negedges waited.
    task automatic wait_gnt(output int n);
        n = 0;
        while (o_gnt == 4'b0000 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (o_gnt == 4'b0000) chk("wait_gnt_timeout", 0, 1);
    endtask

    // Reference model, advanced on every edge the DUT sees.
    initial begin
        int  c;
        bit  found;
        m_owner = -1; m_last = 3; m_sel = 0; m_held = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_last = 3; m_sel = 0; m_held = 0;
            end else if (m_owner < 0) begin
                if (req != 4'b0000) begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        c = (m_last + k) % 4;
                        if (!found && req[c]) begin
                            found   = 1'b1;
                            m_owner = c;
                        end
                    end
                    m_sel  = m_owner;
                    m_last = m_owner;
                    m_held = 1;
                end
            end else begin
                if (done || !req[m_owner] || m_held == MH) m_owner = -1;
                else m_held++;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("model_gnt", int'(o_gnt), (m_owner < 0) ? 0 : (1 << m_owner));
                chk("model_sel", int'(o_sel), m_sel);
                chk("model_busy", int'(o_busy), (m_owner < 0) ? 0 : 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int exp_ch [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", int'(o_gnt), 0);
        chk("reset_sel", int'(o_sel), 0);
        chk("reset_busy", int'(o_busy), 0);
        #2 rst_n = 1'b1;

        // asynchronous reset in the middle of a grant
        @(negedge clk);
        req = 4'b0100;
        wait_gnt(n);
        chk("pre_reset_gnt", int'(o_gnt), 4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_gnt", int'(o_gnt), 0);
        chk("async_reset_sel", int'(o_sel), 0);
        chk("async_reset_busy", int'(o_busy), 0);
        req = 4'b1111;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_gnt(n);
        chk("post_reset_gnt", int'(o_gnt), 1);
        chk("post_reset_sel", int'(o_sel), 0);

        // round robin with done pulsed in the first grant cycle
        for (int i = 0; i < 5; i++) begin
            wait_gnt(n);
            if (i > 0) chk("rr_dead_len", n, 1);
            chk("rr_gnt", int'(o_gnt), 1 << exp_ch[i]);
            chk("rr_sel", int'(o_sel), exp_ch[i]);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            chk("rr_dead_gnt", int'(o_gnt), 0);
            chk("rr_dead_sel", int'(o_sel), exp_ch[i]);
        end
        req = 4'b0000;
        @(negedge clk);

        // hold timeout with a continuous single requester
        req = 4'b0010;
        wait_gnt(n);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            while (o_gnt == 4'b0010 && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("timeout_len", n, MH);
            chk("timeout_dead_gnt", int'(o_gnt), 0);
            chk("timeout_dead_sel", int'(o_sel), 1);
            if (r == 0) begin
                @(negedge clk);
                chk("timeout_regrant", int'(o_gnt), 2);
            end
        end

        // owner withdrawal in its third cycle
        req = 4'b0100;
        wait_gnt(n);
        chk("wd_gnt", int'(o_gnt), 4);
        repeat (2) @(negedge clk);
        req = 4'b1000;
        @(negedge clk);
        chk("wd_release_gnt", int'(o_gnt), 0);
        chk("wd_hold_sel", int'(o_sel), 2);
        @(negedge clk);
        chk("wd_next_gnt", int'(o_gnt), 8);
        chk("wd_next_sel", int'(o_sel), 3);
        req = 4'b0000;
        @(negedge clk);

        // skip and priority from last=1
        req = 4'b0010;
        wait_gnt(n);
        chk("skip_setup_gnt", int'(o_gnt), 2);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1001;
        wait_gnt(n);
        chk("skip_gnt", int'(o_gnt), 8);
        chk("skip_sel", int'(o_sel), 3);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_gnt(n);
        chk("prio_dead_len", n, 1);
        chk("prio_gnt", int'(o_gnt), 1);
        chk("prio_sel", int'(o_sel), 0);
        req = 4'b0000;
        @(negedge clk);

        // done and owner drop together on the timeout cycle
        req = 4'b0100;
        wait_gnt(n);
        repeat (MH - 1) @(negedge clk);
        chk("simul_last_cycle_gnt", int'(o_gnt), 4);
        done = 1'b1;
        req  = 4'b0001;
        @(negedge clk);
        done = 1'b0;
        chk("simul_release_gnt", int'(o_gnt), 0);
        chk("simul_release_sel", int'(o_sel), 2);
        @(negedge clk);
        chk("simul_next_gnt", int'(o_gnt), 1);
        req = 4'b0000;
        @(negedge clk);

        // randomized traffic, checked by the per-cycle comparison process
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        req  = 4'b0000;
        done = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
